// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter that serializes two single-cycle cores onto one data memory.
// Define MEM_ARB_STATS_EN to build the per-port stall-cycle counters (otherwise they read 0).
module mem_bus_arbiter #(
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] AddressBus_0,
    input  logic [DATA_W-1:0] AddressBus_1,
    input  logic [DATA_W-1:0] DataBusOut_0,
    input  logic [DATA_W-1:0] DataBusOut_1,
    input  logic [2:0]        ControlBus_0,
    input  logic [2:0]        ControlBus_1,
    output logic [DATA_W-1:0] DataBusIn_0,
    output logic [DATA_W-1:0] DataBusIn_1,
    output logic              stall_0,
    output logic              stall_1,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [63:0]       wait_cycles_0,
    output logic [63:0]       wait_cycles_1
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;
    logic              r_rr_ptr;
    logic              r_op_write;
    logic              r_mem_we;
    logic              r_mem_re;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [2:0]        w_ctl      [2];
    logic [DATA_W-1:0] w_addr_in  [2];
    logic [DATA_W-1:0] w_wdata_in [2];
    logic [DATA_W-1:0] w_data_in  [2];
    logic [63:0]       w_wait_cnt [2];
    logic [1:0]        w_req;
    logic [1:0]        w_stall;
    logic              w_lat_last;
    logic              w_capture;
    logic              w_start;
    logic              w_grant;
    logic              w_grant_write;
    logic              w_unused_regwrite;

    assign w_ctl[0]      = ControlBus_0;
    assign w_ctl[1]      = ControlBus_1;
    assign w_addr_in[0]  = AddressBus_0;
    assign w_addr_in[1]  = AddressBus_1;
    assign w_wdata_in[0] = DataBusOut_0;
    assign w_wdata_in[1] = DataBusOut_1;

    // RegWriteEn is the core's own concern; the arbiter only looks at the memory enables.
    assign w_unused_regwrite = w_ctl[0][0] ^ w_ctl[1][0];

    assign w_lat_last    = (r_lat_cnt == CNT_W'(MEM_LAT - 1));
    assign w_capture     = (r_state == ST_ACCESS) && w_lat_last && !r_op_write;
    assign w_grant_write = w_ctl[w_grant][2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] r_data_in;

            assign w_req[gi]   = w_ctl[gi][2] | w_ctl[gi][1];
            assign w_stall[gi] = w_req[gi] & ~((r_state == ST_DONE) && (r_owner == 1'(gi)));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_in <= '0;
                end else if (w_capture && (r_owner == 1'(gi))) begin
                    r_data_in <= mem_rdata;
                end
            end
            assign w_data_in[gi] = r_data_in;

`ifdef MEM_ARB_STATS_EN
            logic [63:0] r_wait_cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wait_cnt <= '0;
                end else if (w_stall[gi]) begin
                    r_wait_cnt <= r_wait_cnt + 64'd1;
                end
            end
            assign w_wait_cnt[gi] = r_wait_cnt;
`else
            assign w_wait_cnt[gi] = '0;
`endif
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_grant      = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_start      = 1'b1;
                    w_state_next = ST_ACCESS;
                    w_grant      = (&w_req) ? r_rr_ptr : w_req[1];
                end
            end
            ST_ACCESS: begin
                if (w_lat_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hand straight over to a waiting partner so no IDLE bubble is inserted.
                if (w_req[~r_owner]) begin
                    w_start      = 1'b1;
                    w_state_next = ST_ACCESS;
                    w_grant      = ~r_owner;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_op_write  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_lat_cnt   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= 1'b0;
            if (w_start) begin
                r_owner     <= w_grant;
                r_op_write  <= w_grant_write;
                r_mem_addr  <= w_addr_in[w_grant];
                r_mem_wdata <= w_wdata_in[w_grant];
                r_mem_we    <= w_grant_write;
                r_mem_re    <= ~w_grant_write;
                r_lat_cnt   <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_lat_cnt <= r_lat_cnt + CNT_W'(1);
                if (w_lat_last) begin
                    r_mem_re <= 1'b0;
                    r_rr_ptr <= ~r_rr_ptr;
                end
            end
        end
    end

    assign stall_0       = w_stall[0];
    assign stall_1       = w_stall[1];
    assign DataBusIn_0   = w_data_in[0];
    assign DataBusIn_1   = w_data_in[1];
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_we        = r_mem_we;
    assign mem_re        = r_mem_re;
    assign wait_cycles_0 = w_wait_cnt[0];
    assign wait_cycles_1 = w_wait_cnt[1];
endmodule
